// File: rtl/programmable_address_decoder_pkg.sv
// Shared region-table types, reset contents, table offsets and FSM encoding
// for the programmable bus address decoder.
package addr_dec_pkg;

  localparam int WS_MAX      = 16;
  localparam int DEF_ENTRIES = 4;

  localparam logic [3:0] OFS_BASE = 4'h0;
  localparam logic [3:0] OFS_MASK = 4'h4;
  localparam logic [3:0] OFS_CTRL = 4'h8;

  // ws is sized for the widest supported count; only WS_WIDTH bits are ever written.
  typedef struct packed {
    logic [31:0]       base;
    logic [31:0]       mask;
    logic              en;
    logic [WS_MAX-1:0] ws;
  } region_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DECODE,
    ST_WAIT,
    ST_ACK,
    ST_BERR
  } state_t;

  localparam region_t DEFAULT_TABLE [DEF_ENTRIES] = '{
    '{base: 32'h0000_0000, mask: 32'hFFFF_8000, en: 1'b1, ws: 16'd0},
    '{base: 32'h0040_0000, mask: 32'hFFFF_0000, en: 1'b1, ws: 16'd1},
    '{base: 32'h0800_0000, mask: 32'hFC00_0000, en: 1'b1, ws: 16'd2},
    '{base: 32'hF000_0000, mask: 32'hFFFC_0000, en: 1'b1, ws: 16'd0}
  };

  function automatic region_t default_entry(input int idx);
    region_t r;
    case (idx)
      0:       r = DEFAULT_TABLE[0];
      1:       r = DEFAULT_TABLE[1];
      2:       r = DEFAULT_TABLE[2];
      3:       r = DEFAULT_TABLE[3];
      default: r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/programmable_address_decoder_region_match.sv
// Combinational priority match of an address against the region table;
// lowest enabled matching index wins.
module region_match
  import addr_dec_pkg::*;
#(
  parameter int NUM_REGIONS = 8,
  parameter int IDX_W       = 3
) (
  input  region_t           i_table [NUM_REGIONS],
  input  logic [31:0]       i_addr,
  output logic              o_hit,
  output logic [IDX_W-1:0]  o_idx,
  output logic [WS_MAX-1:0] o_ws
);

  always_comb begin
    o_hit = 1'b0;
    o_idx = '0;
    o_ws  = '0;
    // Scan high to low so the lowest matching index is the last one written.
    for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
      if (i_table[i].en &&
          ((i_addr & i_table[i].mask) == (i_table[i].base & i_table[i].mask))) begin
        o_hit = 1'b1;
        o_idx = IDX_W'(i);
        o_ws  = i_table[i].ws;
      end
    end
  end

endmodule

// File: rtl/programmable_address_decoder.sv
// Table-driven 68k bus decoder: registered selects, Dtack_L ws+2 edges after AS_L,
// bus error after a timeout; the CPU holds AS_L low until acknowledged.
module programmable_address_decoder
  import addr_dec_pkg::*;
#(
  parameter int          NUM_REGIONS    = 8,
  parameter int          WS_WIDTH       = 4,
  parameter int          TIMEOUT_CYCLES = 64,
  parameter logic [31:0] CFG_BASE       = 32'hFF02_0000
) (
  input  logic                   Clk,
  input  logic                   Reset_H,
  input  logic [31:0]            Address,
  input  logic                   AS_L,
  input  logic                   RW,
  input  logic [31:0]            DataIn,
  output logic [NUM_REGIONS-1:0] Select_H,
  output logic                   CfgSelect_H,
  output logic [31:0]            CfgDataOut,
  output logic                   Dtack_L,
  output logic                   BusError_L
);

  localparam int IDX_W = (NUM_REGIONS > 1) ? $clog2(NUM_REGIONS) : 1;
  localparam int TO_W  = $clog2(TIMEOUT_CYCLES);
  localparam int CNT_W = (WS_WIDTH > TO_W) ? WS_WIDTH : TO_W;

  localparam logic [CNT_W-1:0] CNT_TIMEOUT = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

  region_t                r_table [NUM_REGIONS];
  state_t                 r_state, w_state_nxt;
  logic [31:0]            r_addr, r_wdat;
  logic                   r_rw;
  logic [CNT_W-1:0]       r_cnt, w_cnt_nxt;
  logic [NUM_REGIONS-1:0] r_sel, w_sel_nxt;
  logic                   r_cfgsel, w_cfgsel_nxt;
  logic [31:0]            r_cfgdat, w_cfgdat_nxt;
  logic                   r_dtack_l, w_dtack_nxt;
  logic                   r_berr_l, w_berr_nxt;
  logic                   w_latch, w_cfg_wr, w_release;
  logic                   w_cfg_hit;
  logic [3:0]             w_cfg_fld;
  logic [31:0]            w_cfg_rdat;
  logic                   w_hit;
  logic [IDX_W-1:0]       w_idx;
  logic [WS_MAX-1:0]      w_ws;

  region_match #(
    .NUM_REGIONS (NUM_REGIONS),
    .IDX_W       (IDX_W)
  ) u_match (
    .i_table (r_table),
    .i_addr  (r_addr),
    .o_hit   (w_hit),
    .o_idx   (w_idx),
    .o_ws    (w_ws)
  );

  assign w_cfg_hit = (r_addr[31:8] == CFG_BASE[31:8]);
  assign w_cfg_fld = {r_addr[3:2], 2'b00};

  always_comb begin
    w_cfg_rdat = '0;
    for (int i = 0; i < NUM_REGIONS; i++) begin
      if (r_addr[7:4] == 4'(i)) begin
        case (w_cfg_fld)
          OFS_BASE: w_cfg_rdat = r_table[i].base;
          OFS_MASK: w_cfg_rdat = r_table[i].mask;
          OFS_CTRL: w_cfg_rdat = {r_table[i].en, {(31 - WS_MAX){1'b0}}, r_table[i].ws};
          default:  w_cfg_rdat = '0;
        endcase
      end
    end
  end

  // The table only changes on the DECODE edge, after this cycle's region lookup.
  always_ff @(posedge Clk or posedge Reset_H) begin
    if (Reset_H) begin
      for (int i = 0; i < NUM_REGIONS; i++) begin
        r_table[i] <= default_entry(i);
      end
    end else if (w_cfg_wr) begin
      for (int i = 0; i < NUM_REGIONS; i++) begin
        if (r_addr[7:4] == 4'(i)) begin
          case (w_cfg_fld)
            OFS_BASE: r_table[i].base <= r_wdat;
            OFS_MASK: r_table[i].mask <= r_wdat;
            OFS_CTRL: begin
              r_table[i].en <= r_wdat[31];
              r_table[i].ws <= WS_MAX'(r_wdat[WS_WIDTH-1:0]);
            end
            default: ;
          endcase
        end
      end
    end
  end

  always_ff @(posedge Clk or posedge Reset_H) begin
    if (Reset_H) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_sel     <= '0;
      r_cfgsel  <= 1'b0;
      r_cfgdat  <= '0;
      r_dtack_l <= 1'b1;
      r_berr_l  <= 1'b1;
      r_addr    <= '0;
      r_rw      <= 1'b1;
      r_wdat    <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_sel     <= w_sel_nxt;
      r_cfgsel  <= w_cfgsel_nxt;
      r_cfgdat  <= w_cfgdat_nxt;
      r_dtack_l <= w_dtack_nxt;
      r_berr_l  <= w_berr_nxt;
      if (w_latch) begin
        r_addr <= Address;
        r_rw   <= RW;
        r_wdat <= DataIn;
      end
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_sel_nxt    = r_sel;
    w_cfgsel_nxt = r_cfgsel;
    w_cfgdat_nxt = r_cfgdat;
    w_dtack_nxt  = r_dtack_l;
    w_berr_nxt   = r_berr_l;
    w_latch      = 1'b0;
    w_cfg_wr     = 1'b0;
    w_release    = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (!AS_L) begin
          w_latch     = 1'b1;
          w_state_nxt = ST_DECODE;
        end
      end
      ST_DECODE: begin
        if (AS_L) begin
          w_release = 1'b1;
        end else if (w_cfg_hit) begin
          w_cfgsel_nxt = 1'b1;
          if (r_rw) begin
            w_cfgdat_nxt = w_cfg_rdat;
          end else begin
            w_cfg_wr = 1'b1;
          end
          w_state_nxt = ST_ACK;
        end else if (w_hit) begin
          w_sel_nxt   = NUM_REGIONS'(1) << w_idx;
          w_cnt_nxt   = CNT_W'(w_ws);
          w_state_nxt = (w_ws != '0) ? ST_WAIT : ST_ACK;
        end else begin
          w_cnt_nxt   = CNT_TIMEOUT;
          w_state_nxt = ST_BERR;
        end
      end
      ST_WAIT: begin
        if (AS_L) begin
          w_release = 1'b1;
        end else if (r_cnt == CNT_ONE) begin
          w_state_nxt = ST_ACK;
        end else begin
          w_cnt_nxt = r_cnt - CNT_ONE;
        end
      end
      ST_ACK: begin
        if (AS_L) begin
          w_release = 1'b1;
        end else begin
          w_dtack_nxt = 1'b0;
        end
      end
      ST_BERR: begin
        if (AS_L) begin
          w_release = 1'b1;
        end else if (r_cnt == '0) begin
          w_berr_nxt = 1'b0;
        end else begin
          w_cnt_nxt = r_cnt - CNT_ONE;
        end
      end
      default: w_release = 1'b1;
    endcase

    if (w_release) begin
      w_state_nxt  = ST_IDLE;
      w_cnt_nxt    = '0;
      w_sel_nxt    = '0;
      w_cfgsel_nxt = 1'b0;
      w_cfgdat_nxt = '0;
      w_dtack_nxt  = 1'b1;
      w_berr_nxt   = 1'b1;
    end
  end

  assign Select_H    = r_sel;
  assign CfgSelect_H = r_cfgsel;
  assign CfgDataOut  = r_cfgdat;
  assign Dtack_L     = r_dtack_l;
  assign BusError_L  = r_berr_l;

endmodule

// File: tb/tb_programmable_address_decoder.sv
// Bench for the programmable address decoder: a table model predicts each bus
// cycle's outcome and a per-cycle compare process checks all outputs against it.
module tb_programmable_address_decoder;

  localparam int NR     = 8;
  localparam int TO     = 64;
  localparam int K_NONE = 0;
  localparam int K_REG  = 1;
  localparam int K_CFG  = 2;

  logic          Clk = 1'b0;
  logic          Reset_H;
  logic [31:0]   Address;
  logic          AS_L;
  logic          RW;
  logic [31:0]   DataIn;
  logic [NR-1:0] Select_H;
  logic          CfgSelect_H;
  logic [31:0]   CfgDataOut;
  logic          Dtack_L;
  logic          BusError_L;

  programmable_address_decoder #(
    .NUM_REGIONS    (NR),
    .WS_WIDTH       (4),
    .TIMEOUT_CYCLES (TO),
    .CFG_BASE       (32'hFF02_0000)
  ) dut (
    .Clk         (Clk),
    .Reset_H     (Reset_H),
    .Address     (Address),
    .AS_L        (AS_L),
    .RW          (RW),
    .DataIn      (DataIn),
    .Select_H    (Select_H),
    .CfgSelect_H (CfgSelect_H),
    .CfgDataOut  (CfgDataOut),
    .Dtack_L     (Dtack_L),
    .BusError_L  (BusError_L)
  );

  always #5 Clk = ~Clk;

  int n_chk  = 0;
  int n_fail = 0;
  int k      = 0;
  bit chk_en = 1'b0;

  // Expected outcome of the bus cycle in flight.
  int          exp_kind;
  int          exp_idx;
  int          exp_ws;
  bit          exp_rd_op;
  logic [31:0] exp_rdat;

  // Region table model.
  logic [31:0] m_base [NR];
  logic [31:0] m_mask [NR];
  bit          m_en   [NR];
  int          m_ws   [NR];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NR; i++) begin
      m_base[i] = '0;
      m_mask[i] = '0;
      m_en[i]   = 1'b0;
      m_ws[i]   = 0;
    end
    m_base[0] = 32'h0000_0000; m_mask[0] = 32'hFFFF_8000; m_en[0] = 1'b1; m_ws[0] = 0;
    m_base[1] = 32'h0040_0000; m_mask[1] = 32'hFFFF_0000; m_en[1] = 1'b1; m_ws[1] = 1;
    m_base[2] = 32'h0800_0000; m_mask[2] = 32'hFC00_0000; m_en[2] = 1'b1; m_ws[2] = 2;
    m_base[3] = 32'hF000_0000; m_mask[3] = 32'hFFFC_0000; m_en[3] = 1'b1; m_ws[3] = 0;
  endtask

  function automatic logic [31:0] model_read(input logic [7:0] ofs);
    int i;
    int f;
    i = int'(ofs[7:4]);
    f = int'(ofs[3:2]);
    if (i >= NR) return 32'h0;
    case (f)
      0:       return m_base[i];
      1:       return m_mask[i];
      2:       return {m_en[i], 31'(m_ws[i])};
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_write(input logic [7:0] ofs, input logic [31:0] d);
    int i;
    int f;
    i = int'(ofs[7:4]);
    f = int'(ofs[3:2]);
    if (i < NR) begin
      case (f)
        0: m_base[i] = d;
        1: m_mask[i] = d;
        2: begin
          m_en[i] = d[31];
          m_ws[i] = int'(d[3:0]);
        end
        default: ;
      endcase
    end
  endtask

  task automatic predict(input logic [31:0] a, input bit rd);
    exp_kind  = K_NONE;
    exp_idx   = 0;
    exp_ws    = 0;
    exp_rd_op = rd;
    exp_rdat  = '0;
    if (a[31:8] == 24'hFF0200) begin
      exp_kind = K_CFG;
      exp_rdat = model_read(a[7:0]);
    end else begin
      for (int i = 0; i < NR; i++) begin
        if (m_en[i] && ((a & m_mask[i]) == (m_base[i] & m_mask[i]))) begin
          exp_kind = K_REG;
          exp_idx  = i;
          exp_ws   = m_ws[i];
          break;
        end
      end
    end
  endtask

  // k counts clock edges that have seen AS_L low in the current bus cycle.
  always @(posedge Clk) k <= AS_L ? 0 : k + 1;

  logic [NR-1:0] e_sel;
  logic          e_cfg;
  logic [31:0]   e_dat;
  logic          e_dt;
  logic          e_be;
  int            lat;

  always @(posedge Clk) begin
    #1;
    if (chk_en) begin
      e_sel = '0;
      e_cfg = 1'b0;
      e_dat = '0;
      e_dt  = 1'b1;
      e_be  = 1'b1;
      if (k >= 2) begin
        lat = k - 1;
        if (exp_kind == K_REG) begin
          e_sel = NR'(1) << exp_idx;
          if (lat >= exp_ws + 2) e_dt = 1'b0;
        end else if (exp_kind == K_CFG) begin
          e_cfg = 1'b1;
          if (exp_rd_op) e_dat = exp_rdat;
          if (lat >= 2) e_dt = 1'b0;
        end else begin
          if (lat >= TO + 1) e_be = 1'b0;
        end
      end
      check("cyc_select",    32'(Select_H),    32'(e_sel));
      check("cyc_cfgselect", 32'(CfgSelect_H), 32'(e_cfg));
      check("cyc_cfgdata",   CfgDataOut,       e_dat);
      check("cyc_dtack",     32'(Dtack_L),     32'(e_dt));
      check("cyc_buserror",  32'(BusError_L),  32'(e_be));
    end
  end

  task automatic bus(input logic [31:0] a, input bit rd, input logic [31:0] d, input int hold,
                     output int lat_d, output int lat_b, output logic [NR-1:0] sel_seen,
                     output logic [31:0] rdat);
    predict(a, rd);
    lat_d    = -1;
    lat_b    = -1;
    sel_seen = '0;
    rdat     = '0;
    @(negedge Clk);
    Address = a;
    RW      = rd;
    DataIn  = d;
    AS_L    = 1'b0;
    for (int e = 0; e < hold; e++) begin
      @(posedge Clk);
      #1;
      if (!Dtack_L && lat_d < 0) lat_d = e;
      if (!BusError_L && lat_b < 0) lat_b = e;
      sel_seen |= Select_H;
      if (CfgSelect_H) rdat = CfgDataOut;
    end
    @(negedge Clk);
    AS_L = 1'b1;
    @(posedge Clk);
    #1;
    if (exp_kind == K_CFG && !rd && hold >= 2) model_write(a[7:0], d);
  endtask

  int            ld;
  int            lb;
  logic [NR-1:0] sel;
  logic [31:0]   rd;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got %0d checks, expected completion", n_chk);
    $fatal(1, "watchdog");
  end

  initial begin
    Reset_H = 1'b1;
    AS_L    = 1'b1;
    RW      = 1'b1;
    Address = '0;
    DataIn  = '0;
    model_reset();
    #8;
    check("rst_select",    32'(Select_H),    32'h0);
    check("rst_cfgselect", 32'(CfgSelect_H), 32'h0);
    check("rst_cfgdata",   CfgDataOut,       32'h0);
    check("rst_dtack",     32'(Dtack_L),     32'h1);
    check("rst_buserror",  32'(BusError_L),  32'h1);
    @(negedge Clk);
    Reset_H = 1'b0;
    @(negedge Clk);
    chk_en = 1'b1;

    bus(32'h0000_1234, 1'b1, 32'h0, 4, ld, lb, sel, rd);
    check("rom_latency", 32'(ld), 32'd2);
    check("rom_select",  32'(sel), 32'h01);

    bus(32'h0800_0010, 1'b1, 32'h0, 6, ld, lb, sel, rd);
    check("dram_latency", 32'(ld), 32'd4);
    check("dram_select",  32'(sel), 32'h04);

    bus(32'h0040_0004, 1'b0, 32'h1234_5678, 5, ld, lb, sel, rd);
    check("io_latency", 32'(ld), 32'd3);
    check("io_select",  32'(sel), 32'h02);

    bus(32'hFF02_0040, 1'b0, 32'hC000_0000, 3, ld, lb, sel, rd);
    check("cfg_wr_latency", 32'(ld), 32'd2);
    bus(32'hFF02_0044, 1'b0, 32'hFFF0_0000, 3, ld, lb, sel, rd);
    bus(32'hFF02_0048, 1'b0, 32'h8000_0003, 3, ld, lb, sel, rd);

    bus(32'hFF02_0048, 1'b1, 32'h0, 3, ld, lb, sel, rd);
    check("r4_ctrl_read", rd, 32'h8000_0003);
    check("cfg_rd_nosel", 32'(sel), 32'h0);
    bus(32'hFF02_0040, 1'b1, 32'h0, 3, ld, lb, sel, rd);
    check("r4_base_read", rd, 32'hC000_0000);
    bus(32'hFF02_004C, 1'b1, 32'h0, 3, ld, lb, sel, rd);
    check("r4_pad_read", rd, 32'h0);
    check("pad_rd_latency", 32'(ld), 32'd2);
    bus(32'hFF02_00C0, 1'b1, 32'h0, 3, ld, lb, sel, rd);
    check("oob_entry_read", rd, 32'h0);

    bus(32'hC000_0100, 1'b1, 32'h0, 7, ld, lb, sel, rd);
    check("r4_latency", 32'(ld), 32'd5);
    check("r4_select",  32'(sel), 32'h10);

    bus(32'h5000_0000, 1'b1, 32'h0, TO + 3, ld, lb, sel, rd);
    check("unmapped_berr_latency", 32'(lb), 32'(TO + 1));
    check("unmapped_no_dtack",     32'(ld), 32'hFFFF_FFFF);
    check("unmapped_no_select",    32'(sel), 32'h0);
    check("unmapped_berr_release", 32'(BusError_L), 32'h1);

    bus(32'hFF02_0040, 1'b0, 32'h0000_0000, 3, ld, lb, sel, rd);
    bus(32'hFF02_0044, 1'b0, 32'hFFFF_0000, 3, ld, lb, sel, rd);
    bus(32'h0000_0100, 1'b1, 32'h0, 4, ld, lb, sel, rd);
    check("overlap_r0_wins", 32'(sel), 32'h01);
    check("overlap_latency", 32'(ld), 32'd2);
    bus(32'h0000_9000, 1'b1, 32'h0, 7, ld, lb, sel, rd);
    check("overlap_r4_only", 32'(sel), 32'h10);
    check("overlap_r4_lat",  32'(ld), 32'd5);

    bus(32'h0800_0010, 1'b1, 32'h0, 3, ld, lb, sel, rd);
    check("abort_no_dtack",  32'(ld), 32'hFFFF_FFFF);
    check("abort_sel_seen",  32'(sel), 32'h04);
    check("abort_sel_clear", 32'(Select_H), 32'h0);

    bus(32'hFF02_0048, 1'b0, 32'h0000_0000, 1, ld, lb, sel, rd);
    bus(32'hFF02_0048, 1'b1, 32'h0, 3, ld, lb, sel, rd);
    check("aborted_write_dropped", rd, 32'h8000_0003);

    @(negedge Clk);
    predict(32'h0800_0010, 1'b1);
    Address = 32'h0800_0010;
    RW      = 1'b1;
    AS_L    = 1'b0;
    @(posedge Clk);
    @(posedge Clk);
    #1;
    check("rst_mid_pre_select", 32'(Select_H), 32'h04);
    #2;
    chk_en  = 1'b0;
    Reset_H = 1'b1;
    #1;
    check("rst_mid_select",   32'(Select_H),    32'h0);
    check("rst_mid_dtack",    32'(Dtack_L),     32'h1);
    check("rst_mid_buserror", 32'(BusError_L),  32'h1);
    check("rst_mid_cfgsel",   32'(CfgSelect_H), 32'h0);
    AS_L = 1'b1;
    model_reset();
    @(negedge Clk);
    Reset_H = 1'b0;
    @(posedge Clk);
    @(negedge Clk);
    chk_en = 1'b1;

    bus(32'hFF02_0048, 1'b1, 32'h0, 3, ld, lb, sel, rd);
    check("rst_r4_ctrl_default", rd, 32'h0);
    bus(32'hFF02_0040, 1'b1, 32'h0, 3, ld, lb, sel, rd);
    check("rst_r4_base_default", rd, 32'h0);
    bus(32'hC000_0100, 1'b1, 32'h0, TO + 3, ld, lb, sel, rd);
    check("rst_r4_unmapped", 32'(lb), 32'(TO + 1));
    bus(32'h0000_1234, 1'b1, 32'h0, 4, ld, lb, sel, rd);
    check("rst_rom_latency", 32'(ld), 32'd2);

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/programmable_address_decoder.md
Name: programmable_address_decoder

Overview:
- Next-generation bus address decoder for the 68k-style system bus. Replaces the fixed combinational decode with a table of NUM_REGIONS programmable regions (base, mask, enable, wait states).
- Generates the registered chip selects, a wait-state-timed Dtack_L, and a bus error for unmapped accesses.
- Sits between the CPU bus and all memory/peripheral selects. The region table is itself memory-mapped at CFG_BASE.

Parameters:
- NUM_REGIONS, 8, number of decode regions; lower index has higher priority.
- WS_WIDTH, 4, width of the per-region wait-state count.
- TIMEOUT_CYCLES, 64, cycles before an unmapped access raises bus error.
- CFG_BASE, 32'hFF02_0000, base address of the region table (256-byte window, full decode of [31:8]).

Ports:
- Clk  in  1  system clock; all state on rising edge.
- Reset_H  in  1  asynchronous, active-high reset.
- Address  in  32  CPU byte address.
- AS_L  in  1  address strobe, active low.
- RW  in  1  1 = read, 0 = write.
- DataIn  in  32  CPU write data, used for table writes.
- Select_H  out  NUM_REGIONS  one-hot registered region selects.
- CfgSelect_H  out  1  table access in progress.
- CfgDataOut  out  32  table read data.
- Dtack_L  out  1  data acknowledge, active low.
- BusError_L  out  1  bus error, active low.

Behaviour:
- Reset (async): Select_H = 0, CfgSelect_H = 0, CfgDataOut = 0, Dtack_L = 1, BusError_L = 1, FSM = IDLE.
- Table contents on reset; all other regions are disabled with base/mask/ws = 0:
  - R0: base 0000_0000, mask FFFF_8000, ws 0, en 1 (ROM).
  - R1: base 0040_0000, mask FFFF_0000, ws 1, en 1 (IO).
  - R2: base 0800_0000, mask FC00_0000, ws 2, en 1 (DRAM).
  - R3: base F000_0000, mask FFFC_0000, ws 0, en 1 (RAM).
- Match rule: region i matches when en_i and (Address & mask_i) == (base_i & mask_i). The winner is the lowest matching index.
- Priority: a config-window hit overrides every region.
- Table map: offset 16*i + 0 = base, +4 = mask, +8 = {en bit 31, ws in [WS_WIDTH-1:0]}. Offsets +C, and offsets for i >= NUM_REGIONS, read 0 and ignore writes.
- FSM states: IDLE, DECODE, WAIT, ACK, BERR.
- IDLE: on AS_L = 0 sampled, go to DECODE. Address, RW and DataIn are latched.
- DECODE (1 cycle), on the next edge:
  - Config hit: CfgSelect_H = 1. Write updates the table entry; read loads CfgDataOut. Go to ACK.
  - Region hit: Select_H[i] = 1, counter = ws_i. Go to WAIT if ws_i != 0, otherwise ACK.
  - No hit: counter = TIMEOUT_CYCLES-1, go to BERR-count.
- WAIT: decrement counter; at 1, go to ACK.
  - Latency from AS_L sampled low to Dtack_L low is ws+2 edges.
- ACK: Dtack_L = 0; hold until AS_L = 1 sampled. Then clear all outputs and go to IDLE.
- BERR: the counter counts down to 0, then BusError_L = 0. Hold until AS_L = 1, then go to IDLE.
- AS_L = 1 sampled in DECODE, WAIT or BERR-count (aborted cycle): outputs clear on the next edge, go to IDLE. A pending table write is discarded if the abort occurs before the DECODE edge.
- Table writes take effect for the next bus cycle, never the current one.
- A write that disables the region containing the table window is legal, because the config window is decoded first.
- Reset asserted mid-cycle: all outputs go inactive immediately and the table reloads its defaults.
- Counter width = max(WS_WIDTH, clog2(TIMEOUT_CYCLES)). ws = 0 gives no wait cycles.

Decomposition:
- Package addr_dec_pkg:
  - region_t struct {base, mask, en, ws}.
  - Reset-default table array.
  - Config offset constants.
  - FSM state enum.
- Sub-module region_match: purely combinational. Takes the table plus address; outputs a hit flag and the winning index (priority encoder). Instantiated once.

Test Plan:
- After reset, read at 0000_1234 -> Select_H = 0000_0001, Dtack_L low 2 cycles after AS_L, released 1 cycle after AS_L high.
- Access at 0800_0010 (R2, ws 2) -> Select_H[2] = 1, Dtack_L low 4 edges after AS_L; IO 0040_0004 -> Dtack_L at 3 edges.
- Remap R4 (checks the table write/read path and that the new region decodes):
  - Write FF02_0040 = C000_0000, FF02_0044 = FFF0_0000, FF02_0048 = 8000_0003.
  - Read back FF02_0048 -> CfgDataOut = 8000_0003.
  - Access C000_0100 -> Select_H[4], Dtack_L after 5 edges.
- Access 5000_0000 (unmapped) -> no Select_H, BusError_L low after TIMEOUT_CYCLES+1 edges, released on AS_L high.
- Overlap and abort:
  - R4 programmed to overlap R0 (base 0, mask FFFF_0000) -> access 0000_0100 selects R0 only.
  - AS_L raised during WAIT -> Select_H clears next edge, no Dtack_L.
- Reset asserted during WAIT of a DRAM cycle -> outputs inactive without a clock edge; a subsequent read of R4 config returns 0 (defaults restored).
